// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// ---------------------------------------------------------------------------
// Shares one single-port pixel SRAM between the VGA scanout and a pixel
// writer. Each line_start pulse prefetches LINE_LEN words from line_base
// into a small show-ahead FIFO that the display driver pops from. Reads take
// priority; the writer is granted every memory cycle the prefetch leaves idle.
//
// Optional feature macro: VGA_FB_ARB_WR_FAIRNESS_EN
//   When defined, a 3-bit streak counter forces one write slot after seven
//   consecutive reads whenever the writer is waiting.
//
// Ports
//   clk, rst_n               : clock, synchronous active-low reset
//   line_start, line_base    : start (or restart) prefetch of a line
//   pix_pop, pix_data,
//   pix_empty, underflow     : scanout side of the prefetch FIFO
//   wr_valid, wr_ready,
//   wr_addr, wr_data         : writer request / grant
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata     : SRAM port, read data valid 1 cycle after read
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 12,
    parameter int LINE_LEN   = 1280,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] line_base,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_empty,
    output logic              underflow,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REM_W = $clog2(LINE_LEN + 1);
    localparam logic [REM_W-1:0] LINE_LEN_R = REM_W'(LINE_LEN);
    localparam logic [CNT_W:0]   DEPTH_R    = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
    logic [REM_W-1:0]    remaining_reg, remaining_next;
    logic                inflight_reg;
    logic                stale_reg;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                underflow_reg;

    logic                rd_go_base, rd_go;
    logic                restart, push, pop_ok;
    logic [CNT_W:0]      occupancy;

    // A read in flight already owns a FIFO slot, so it counts toward occupancy.
    assign occupancy  = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign rd_go_base = rst_n && (state_reg == FETCH) && (remaining_reg != '0)
                        && (occupancy < DEPTH_R);

`ifdef VGA_FB_ARB_WR_FAIRNESS_EN
    logic [2:0] rd_streak_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_streak_reg <= 3'd0;
        end else begin
            rd_streak_reg <= rd_go ? rd_streak_reg + 3'd1 : 3'd0;
        end
    end

    // After seven back-to-back reads a waiting writer steals the eighth slot.
    assign rd_go = rd_go_base & ~((rd_streak_reg == 3'd7) & wr_valid);
`else
    assign rd_go = rd_go_base;
`endif

    // line_start during FETCH restarts the line: FIFO is flushed and the
    // read returning on that edge belongs to the old line, so it is dropped.
    assign restart   = line_start & (state_reg == FETCH);
    assign push      = rst_n & inflight_reg & ~stale_reg & ~restart;
    assign pix_empty = (count_reg == '0);
    assign pop_ok    = pix_pop & ~pix_empty;
    assign underflow = underflow_reg;
    assign pix_data  = pix_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign wr_ready  = rst_n & ~rd_go;

    // Next-state logic; line_start overrides the read advance.
    always_comb begin
        state_next     = state_reg;
        rd_addr_next   = rd_addr_reg;
        remaining_next = remaining_reg;
        if (rd_go) begin
            rd_addr_next   = rd_addr_reg + 1'b1;
            remaining_next = remaining_reg - 1'b1;
            if (remaining_reg == REM_W'(1)) begin
                state_next = IDLE;
            end
        end
        if (line_start) begin
            state_next     = FETCH;
            rd_addr_next   = line_base;
            remaining_next = LINE_LEN_R;
        end
    end

    // SRAM port mux: prefetch read first, writer otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_go) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr_reg;
        end else if (wr_valid && wr_ready) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rd_addr_reg   <= '0;
            remaining_reg <= '0;
            inflight_reg  <= 1'b0;
            stale_reg     <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_addr_reg   <= rd_addr_next;
            remaining_reg <= remaining_next;
            inflight_reg  <= rd_go;
            // A read issued on the restart cycle still targets the old line.
            stale_reg     <= rd_go & restart;
            if (pix_pop && pix_empty) begin
                underflow_reg <= 1'b1;
            end
            if (restart) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                case ({push, pop_ok})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // FIFO storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
// Drives vga_fb_arbiter with a directed opening (reset, writer in idle,
// prefetch, backpressure, restart) followed by randomized traffic. A queue
// based model of the line fetch and FIFO predicts every output each cycle.
module tb_vga_fb_arbiter;
    localparam int AW = 12;
    localparam int DW = 12;
    localparam int LL = 20;
    localparam int FD = 8;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          line_start;
    logic [AW-1:0] line_base;
    logic          pix_pop;
    logic [DW-1:0] pix_data;
    logic          pix_empty;
    logic          underflow;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_LEN(LL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .line_start(line_start), .line_base(line_base),
        .pix_pop(pix_pop), .pix_data(pix_data), .pix_empty(pix_empty),
        .underflow(underflow),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM: word i initially holds (7*i + 3) mod 4096.
    logic [DW-1:0] sram [MSZ];
    bit            sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < MSZ; i++) sram[i] <= DW'(i * 7 + 3);
            sram_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [MSZ];
    logic [DW-1:0] m_q [$];
    bit            model_on = 1'b0;
    bit            m_init = 1'b0;
    bit            m_fetch, m_infl, m_stale, m_uf;
    int            m_addr, m_rem, m_streak;
    logic [DW-1:0] m_ret;

    always @(negedge clk) begin
        bit go, wr, restart;
        if (!m_init) begin
            for (int i = 0; i < MSZ; i++) m_mem[i] = DW'(i * 7 + 3);
            m_init = 1'b1;
        end
        if (!rst_n) begin
            if (model_on) begin
                check("rst_mem_en", 32'(mem_en), 32'd0);
                check("rst_wr_ready", 32'(wr_ready), 32'd0);
            end
            m_q.delete();
            m_fetch = 0; m_infl = 0; m_stale = 0; m_uf = 0;
            m_addr = 0; m_rem = 0; m_streak = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            go = m_fetch && (m_rem > 0) && (m_q.size() + (m_infl ? 1 : 0) < FD);
`ifdef VGA_FB_ARB_WR_FAIRNESS_EN
            if (m_streak == 7 && wr_valid) go = 0;
`endif
            wr = !go && wr_valid;
            check("wr_ready", 32'(wr_ready), 32'(!go));
            check("mem_en", 32'(mem_en), 32'(go || wr));
            if (go || wr) begin
                check("mem_we", 32'(mem_we), 32'(wr));
                check("mem_addr", 32'(mem_addr), go ? 32'(m_addr) : 32'(wr_addr));
                if (wr) check("mem_wdata", 32'(mem_wdata), 32'(wr_data));
            end
            check("pix_empty", 32'(pix_empty), 32'(m_q.size() == 0));
            if (m_q.size() > 0) check("pix_data", 32'(pix_data), 32'(m_q[0]));
            check("underflow", 32'(underflow), 32'(m_uf));

            // advance the model across the coming edge
            restart = line_start && m_fetch;
            if (pix_pop) begin
                if (m_q.size() == 0) m_uf = 1;
                else void'(m_q.pop_front());
            end
            if (m_infl && !m_stale && !restart) m_q.push_back(m_ret);
            if (restart) m_q.delete();
            m_infl  = go;
            m_stale = go && restart;
            if (go) m_ret = m_mem[m_addr];
            m_streak = go ? (m_streak + 1) % 8 : 0;
            if (go) begin
                m_addr = (m_addr + 1) % MSZ;
                m_rem--;
                if (m_rem == 0) m_fetch = 0;
            end
            if (line_start) begin
                m_fetch = 1;
                m_addr  = int'(line_base);
                m_rem   = LL;
            end
            if (wr) m_mem[wr_addr] = wr_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nrd;
        rst_n = 0; line_start = 0; line_base = '0; pix_pop = 0;
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pix_empty", 32'(pix_empty), 32'd1);
        check("reset_mem_en", 32'(mem_en), 32'd0);
        check("reset_wr_ready", 32'(wr_ready), 32'd0);
        check("reset_underflow", 32'(underflow), 32'd0);

        // writer in IDLE gets the port at once
        next_cycle();
        rst_n = 1; wr_valid = 1; wr_addr = 12'h055; wr_data = 12'hABC;
        @(negedge clk);
        check("idle_wr_ready", 32'(wr_ready), 32'd1);
        check("idle_mem_we", 32'(mem_we), 32'd1);
        check("idle_mem_addr", 32'(mem_addr), 32'h055);

        // prefetch of line 0x100 with no pops
        next_cycle();
        wr_valid = 0; line_start = 1; line_base = 12'h100;
        next_cycle();
        line_start = 0; wr_valid = 1; wr_addr = 12'h077; wr_data = 12'h123;
        nrd = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (mem_en && !mem_we) nrd++;
            if (c <= 4) begin
                check("pf_rd_en", 32'(mem_en && !mem_we), 32'd1);
                check("pf_rd_addr", 32'(mem_addr), 32'h100 + 32'(c - 1));
            end
            if (c == 1) check("burst_wr_ready", 32'(wr_ready), 32'd0);
            if (c == 2) check("pf_empty_c2", 32'(pix_empty), 32'd1);
            if (c == 3) begin
                check("pf_empty_c3", 32'(pix_empty), 32'd0);
                check("pf_data_c3", 32'(pix_data), 32'h703);
            end
            next_cycle();
            wr_valid = 0;
        end
        check("bp_read_count", 32'(nrd), 32'd8);

        // one pop frees exactly one slot, used on the next cycle
        pix_pop = 1;
        @(negedge clk);
        check("bp_pop_cycle_idle", 32'(mem_en), 32'd0);
        next_cycle();
        pix_pop = 0;
        @(negedge clk);
        check("bp_refill_en", 32'(mem_en && !mem_we), 32'd1);
        check("bp_refill_addr", 32'(mem_addr), 32'h108);
        next_cycle();
        @(negedge clk);
        check("bp_after_refill", 32'(mem_en), 32'd0);

        // restart 0x300, then 0x200 one cycle after the first read
        next_cycle();
        line_start = 1; line_base = 12'h300;
        next_cycle();
        line_start = 0;
        @(negedge clk);
        check("rs_first_addr", 32'(mem_addr), 32'h300);
        next_cycle();
        line_start = 1; line_base = 12'h200;
        @(negedge clk);
        check("rs_stale_addr", 32'(mem_addr), 32'h301);
        next_cycle();
        line_start = 0;
        @(negedge clk);
        check("rs_new_addr", 32'(mem_addr), 32'h200);
        check("rs_empty_a", 32'(pix_empty), 32'd1);
        next_cycle();
        @(negedge clk);
        check("rs_empty_b", 32'(pix_empty), 32'd1);
        next_cycle();
        @(negedge clk);
        check("rs_empty_c", 32'(pix_empty), 32'd0);
        check("rs_data", 32'(pix_data), 32'hE03);

        // randomized traffic, including restarts, wrap and mid-line resets
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst_n      = ($urandom_range(0, 399) != 0);
            line_start = ($urandom_range(0, 39) == 0);
            line_base  = ($urandom_range(0, 3) == 0) ? AW'(12'hFF0 + $urandom_range(0, 15))
                                                      : AW'($urandom);
            pix_pop    = ($urandom_range(0, 9) < 6);
            wr_valid   = $urandom_range(0, 1) == 1;
            wr_addr    = AW'($urandom);
            wr_data    = DW'($urandom);
        end
        next_cycle();
        rst_n = 1; line_start = 0; pix_pop = 0; wr_valid = 0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Framebuffer controller that shares one single-port pixel SRAM between two requesters: the VGA scanout and a pixel writer. The scanout must never stall. The block prefetches one display line at a time into an internal show-ahead FIFO, and the driver pops pixels from it during the active region. Writer requests are granted on every memory cycle that the prefetch does not need.

## Interface
Parameters:
- `ADDR_W`, default 21: framebuffer word address width.
- `DATA_W`, default 12: pixel width (4:4:4 RGB).
- `LINE_LEN`, default 1280: words fetched per `line_start`.
- `FIFO_DEPTH`, default 8: prefetch FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `line_start`, in, 1: one-cycle pulse that begins prefetch of a new line.
- `line_base`, in, `ADDR_W`: first word address of the line. Sampled when `line_start` is high.
- `pix_pop`, in, 1: consume the FIFO head.
- `pix_data`, out, `DATA_W`: FIFO head (show-ahead).
- `pix_empty`, out, 1: FIFO holds no valid entry.
- `underflow`, out, 1: sticky flag, set by a pop while empty.
- `wr_valid`, in, 1: writer request.
- `wr_ready`, out, 1: writer granted this cycle.
- `wr_addr`, in, `ADDR_W`: writer target address.
- `wr_data`, in, `DATA_W`: writer data.
- `mem_en`, out, 1: SRAM access strobe.
- `mem_we`, out, 1: 1 = write, 0 = read.
- `mem_addr`, out, `ADDR_W`: SRAM address.
- `mem_wdata`, out, `DATA_W`: SRAM write data.
- `mem_rdata`, in, `DATA_W`: SRAM read data. Valid exactly 1 cycle after a read.

## Operation
- FSM states: IDLE and FETCH.
- IDLE → FETCH on `line_start`. This loads `rd_addr=line_base` and `remaining=LINE_LEN`.
- FETCH → IDLE on the cycle the last read is issued (`remaining` reaches 0).
- `line_start` while in FETCH restarts the prefetch from the new `line_base` and flushes the FIFO in the same edge. A read issued in the cycle of the `line_start` pulse is marked stale, and its data is discarded when it returns.
- Read issue condition (`rd_go`): state is FETCH, `remaining != 0`, and `fifo_count + inflight < FIFO_DEPTH`. `inflight` is 0 or 1.
- On `rd_go`: `mem_en=1`, `mem_we=0`, `mem_addr=rd_addr`, `rd_addr+1`, `remaining-1`.
- Address arithmetic is modulo 2^`ADDR_W`. Wrap-around is permitted and not flagged.
- Writer grant: `wr_ready = rst_n & ~rd_go`. `wr_ready` does not depend on `wr_valid`.
- On `wr_valid & wr_ready`: `mem_en=1`, `mem_we=1`, `mem_addr=wr_addr`, `mem_wdata=wr_data`.
- `mem_en=0` when neither side accesses. `mem_*` and `wr_ready` are combinational from registered state plus `wr_valid`.
- FIFO push: returned read data is pushed the cycle after issue, unless it is stale.
- Push and pop in the same cycle: the count is unchanged.
- Pop while empty: FIFO state is unchanged and `underflow` is set. `underflow` is cleared only by reset.

## Timing
- Read issued in cycle t. `mem_rdata` is captured at the end of t+1. `pix_empty` falls at t+2 and `pix_data` is valid at t+2.
- Steady state: one read per cycle while the FIFO has space.
- A pop in cycle t frees an issue slot in cycle t+1.
- Reset values: state=IDLE, FIFO empty, `pix_empty=1`, `pix_data=0`, `underflow=0`, `inflight=0`, `mem_en=0`, `mem_we=0`, `wr_ready=0`.
- Reset asserted mid-FETCH aborts at that edge, and in-flight data is dropped.

## Configuration
- `VGA_FB_ARB_WR_FAIRNESS_EN` defined:
  - A 3-bit counter `rd_streak` increments on each `rd_go` cycle and clears on any other cycle.
  - When `rd_streak==7` and `wr_valid=1`, `rd_go` is forced to 0 and the writer takes the slot.
  - The writer is therefore guaranteed at least one slot in every 8 cycles.
- Not defined: the counter is absent and reads always have priority.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles → `pix_empty=1`, `mem_en=0`, `wr_ready=0`, `underflow=0`.
- Prefetch: `line_start` with `line_base=0x100` and `LINE_LEN=4`, no pops → reads at 0x100–0x103 on consecutive cycles, `pix_empty` falls 2 cycles after the first read, FSM returns to IDLE.
- Backpressure: `FIFO_DEPTH=8`, `LINE_LEN=20`, no pops → exactly 8 reads issue and then `mem_en` stays 0. One pop → exactly one further read the next cycle.
- Arbitration:
  - IDLE with `wr_valid=1`, `wr_addr=0x55`, `wr_data=0xABC` → same cycle `wr_ready=1`, `mem_we=1`, `mem_addr=0x55`.
  - During a read burst → `wr_ready=0`.
- Restart: second `line_start` (base 0x200) one cycle after a read → FIFO flushed, stale return discarded, next `pix_data` = `mem[0x200]`.
- Fairness (macro on): continuous pops plus `wr_valid=1` → one write every 8th cycle. With the macro off → zero writes until FETCH ends.
